// File: rtl/sub_128_seq.sv
// Multi-cycle M-bit subtractor: diff = a - b - bin, one W-bit chunk per cycle, LSB chunk first.
// Valid/ready on both sides, one operation in flight.
module sub_128_seq #(
  parameter int unsigned M = 128,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] diff,
  output logic         bout
);

  localparam int unsigned NCH  = M / W;
  localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [M-1:0]      a_q, a_d;
  logic [M-1:0]      b_q, b_d;
  logic [M-1:0]      diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              bout_q, bout_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [W:0]        sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    idx_d    = idx_q;
    // W+1-bit difference of the current chunk; the top bit is the borrow out.
    sub = {1'b0, a_q[idx_q*W +: W]} - {1'b0, b_q[idx_q*W +: W]} - {{W{1'b0}}, borrow_q};

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        diff_d[idx_q*W +: W] = sub[W-1:0];
        borrow_d             = sub[W];
        if (idx_q == IdxW'(NCH - 1)) begin
          bout_d  = sub[W];
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_sub_128_seq.sv
// Self-checking bench for sub_128_seq: directed vector table, corner sequences, random traffic.
module tb_sub_128_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a;
  logic [127:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] diff;
  logic         bout;

  int total = 0;
  int bad   = 0;

  sub_128_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] va;
    logic [127:0] vb;
    logic         vbin;
    logic [127:0] ed;
    logic         eb;
  } vec_t;

  vec_t vecs[9];

  logic [128:0] exp_q[$];
  int           got;
  int           cyc;
  bit           abort;

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [127:0] va, input logic [127:0] vb,
                        input logic vbin, input logic [127:0] ed, input logic eb);
    int n;
    a = va;
    b = vb;
    bin = vbin;
    in_valid = 1'b1;
    chk({name, " in_ready before accept"}, 129'(in_ready), 129'(1));
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, " latency"}, 129'(n), 129'(4));
    chk({name, " diff"}, 129'(diff), 129'(ed));
    chk({name, " bout"}, 129'(bout), 129'(eb));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, " out_valid after handshake"}, 129'(out_valid), 129'(0));
    chk({name, " in_ready after handshake"}, 129'(in_ready), 129'(1));
  endtask

  initial begin
    logic [127:0] ones;
    logic [127:0] pat;
    logic [127:0] bp_d;
    int n;
    ones = '1;
    pat  = 128'h0123456789ABCDEF_0123456789ABCDEF;

    vecs[0] = '{"basic",        128'd10, 128'd3, 1'b0, 128'd7, 1'b0};
    vecs[1] = '{"underflow",    128'd0, 128'd1, 1'b0, ones, 1'b1};
    vecs[2] = '{"cross chunk",  128'h00000001_00000000_00000000_00000000, 128'd1, 1'b0,
                128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0};
    vecs[3] = '{"eq bin1",      pat, pat, 1'b1, ones, 1'b1};
    vecs[4] = '{"eq bin0",      pat, pat, 1'b0, 128'd0, 1'b0};
    vecs[5] = '{"max minus bin", ones, 128'd0, 1'b1,
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0};
    vecs[6] = '{"basic bin1",   128'd10, 128'd3, 1'b1, 128'd6, 1'b0};
    vecs[7] = '{"zero bin1",    128'd0, 128'd0, 1'b1, ones, 1'b1};
    vecs[8] = '{"wrap to zero", 128'd0, ones, 1'b1, 128'd0, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    abort = 1'b0;
    got = 0;
    cyc = 0;
    repeat (2) tick();
    chk("reset in_ready", 129'(in_ready), 129'(1));
    chk("reset out_valid", 129'(out_valid), 129'(0));
    chk("reset diff", 129'(diff), 129'(0));
    chk("reset bout", 129'(bout), 129'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vbin, vecs[i].ed, vecs[i].eb);
    end

    // Backpressure with operands scrambled while the operation runs.
    bp_d = 128'h77777776_FFFFFFFF_FFFFFFFE_FFFFFFFF;
    a = 128'h89ABCDEF_00000000_FFFFFFFF_12345678;
    b = 128'h12345678_00000001_00000000_12345679;
    bin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~a;
    b = 128'h5;
    bin = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp latency", 129'(n), 129'(4));
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("bp diff held", 129'(diff), 129'(bp_d));
      chk("bp bout held", 129'(bout), 129'(0));
      chk("bp in_ready low", 129'(in_ready), 129'(0));
      chk("bp out_valid high", 129'(out_valid), 129'(1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp out_valid drop", 129'(out_valid), 129'(0));
    chk("bp in_ready back", 129'(in_ready), 129'(1));

    // Reset two cycles after acceptance.
    a = 128'd100;
    b = 128'd1;
    bin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 129'(out_valid), 129'(0));
    chk("midrst diff", 129'(diff), 129'(0));
    chk("midrst bout", 129'(bout), 129'(0));
    chk("midrst in_ready", 129'(in_ready), 129'(1));
    tick();
    rst_n = 1'b1;
    tick();
    run_op("after reset", 128'd5, 128'd5, 1'b0, 128'd0, 1'b0);

    // Random back-to-back traffic against a 129-bit reference.
    fork
      begin
        logic [127:0] ra;
        logic [127:0] rb;
        logic         rbin;
        int           w;
        for (int i = 0; i < 1000 && !abort; i++) begin
          ra = {$urandom, $urandom, $urandom, $urandom};
          rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom, $urandom, $urandom};
          rbin = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            tick();
          end
          a = ra;
          b = rb;
          bin = rbin;
          in_valid = 1'b1;
          w = 0;
          while (!in_ready && w < 100) begin
            tick();
            w++;
          end
          if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL rnd accept timeout: in_ready got 0 expected 1");
            abort = 1'b1;
          end else begin
            exp_q.push_back({1'b0, ra} - {1'b0, rb} - 129'(rbin));
            tick();
          end
        end
        in_valid = 1'b0;
      end
      begin
        logic [128:0] e;
        while (got < 1000 && cyc < 50000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL rnd extra result: got %h expected none", {bout, diff});
            end else begin
              e = exp_q.pop_front();
              chk("rnd result", {bout, diff}, e);
            end
            got++;
          end
          tick();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    chk("rnd result count", 129'(got), 129'(1000));
    chk("rnd leftover", 129'(exp_q.size()), 129'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
